// File: rtl/cfs_md_responder_pkg.sv
// Shared types and helpers for the MD responder: FSM state encoding, port-width
// functions and the payload right-alignment function.
package cfs_md_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Widest data bus align_bytes can handle; callers zero-extend into it.
    localparam int unsigned MAX_DW = 1024;

    function automatic int offset_width(input int dw);
        return (dw > 8) ? $clog2(dw / 8) : 1;
    endfunction

    function automatic int size_width(input int dw);
        return $clog2(dw / 8) + 1;
    endfunction

    function automatic logic [MAX_DW-1:0] align_bytes(input logic [MAX_DW-1:0] data,
                                                      input int unsigned     offset,
                                                      input int unsigned     size);
        logic [MAX_DW-1:0] shifted;
        shifted = data >> (8 * offset);
        for (int unsigned i = 0; i < MAX_DW / 8; i++) begin
            if (i >= size) begin
                shifted[8*i +: 8] = 8'h00;
            end
        end
        return shifted;
    endfunction

endpackage

// File: rtl/cfs_md_resp_fifo.sv
// Synchronous FIFO with wrap-bit pointers and an occupancy output. A pop is
// applied before a push, so push while full succeeds when a pop happens too.
module cfs_md_resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [AW:0]      level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             pop_s;
    logic             push_s;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    assign pop_s   = pop_i && !empty_o;
    assign push_s  = push_i && (!full_o || pop_s);

    // Pointer update; async reset flushes the FIFO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage write; contents are only observed through valid pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/cfs_md_responder.sv
// MD-protocol responder: wait-state insertion, legality check, payload alignment
// and an output FIFO. Define CFS_MD_RESPONDER_STATS_EN to add completion counters.
module cfs_md_responder
    import cfs_md_responder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int OFFSET_WIDTH = offset_width(DATA_WIDTH),
    localparam int SIZE_WIDTH   = size_width(DATA_WIDTH),
    localparam int LEVEL_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    md_valid,
    input  logic [DATA_WIDTH-1:0]   md_data,
    input  logic [OFFSET_WIDTH-1:0] md_offset,
    input  logic [SIZE_WIDTH-1:0]   md_size,
    output logic                    md_ready,
    output logic                    md_err,
    input  logic [7:0]              wait_cycles,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [SIZE_WIDTH-1:0]   out_size,
    input  logic                    out_ready,
    output logic [LEVEL_WIDTH-1:0]  fifo_level
`ifdef CFS_MD_RESPONDER_STATS_EN
    ,
    output logic [31:0]             cnt_ok,
    output logic [31:0]             cnt_err
`endif
);

    localparam logic [SIZE_WIDTH:0] NUM_BYTES = (SIZE_WIDTH+1)'(DATA_WIDTH / 8);

    state_e                   state_q, state_d;
    logic [7:0]               cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]    req_data_q;
    logic [OFFSET_WIDTH-1:0]  req_off_q;
    logic [SIZE_WIDTH-1:0]    req_size_q;
    logic                     md_ready_q, md_err_q;
    logic [SIZE_WIDTH:0]      byte_end_s;
    logic                     illegal_s, push_s;
    logic                     fifo_full_s, fifo_empty_s;
    logic [MAX_DW-1:0]        aligned_s;
    logic                     aligned_unused_s;
    logic [SIZE_WIDTH+DATA_WIDTH-1:0] fifo_rdata_s;

    // One extra bit on the byte-end sum so offset+size can never wrap into range.
    assign byte_end_s = (SIZE_WIDTH+1)'(req_off_q) + {1'b0, req_size_q};
    assign illegal_s  = (req_size_q == {SIZE_WIDTH{1'b0}}) || (byte_end_s > NUM_BYTES);
    assign aligned_s  = align_bytes({{(MAX_DW-DATA_WIDTH){1'b0}}, req_data_q},
                                    32'(req_off_q), 32'(req_size_q));
    assign aligned_unused_s = ^aligned_s[MAX_DW-1:DATA_WIDTH];

    // Next-state logic: wait countdown, back-pressure hold and abort on dropped valid.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        push_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (md_valid) begin
                    state_d = WAIT;
                    cnt_d   = wait_cycles;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (!md_valid) begin
                    state_d = IDLE;
                end else if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (illegal_s || !fifo_full_s) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                state_d = IDLE;
                push_s  = !illegal_s;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and registered handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            md_ready_q <= 1'b0;
            md_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            md_ready_q <= (state_d == RESP);
            md_err_q   <= (state_d == RESP) && illegal_s;
        end
    end

    // Request capture on acceptance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_data_q <= {DATA_WIDTH{1'b0}};
            req_off_q  <= {OFFSET_WIDTH{1'b0}};
            req_size_q <= {SIZE_WIDTH{1'b0}};
        end else if ((state_q == IDLE) && md_valid) begin
            req_data_q <= md_data;
            req_off_q  <= md_offset;
            req_size_q <= md_size;
        end
    end

    cfs_md_resp_fifo #(
        .WIDTH (SIZE_WIDTH + DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push_s),
        .wdata_i ({req_size_q, aligned_s[DATA_WIDTH-1:0]}),
        .pop_i   (out_ready),
        .rdata_o (fifo_rdata_s),
        .empty_o (fifo_empty_s),
        .full_o  (fifo_full_s),
        .level_o (fifo_level)
    );

    assign md_ready  = md_ready_q;
    assign md_err    = md_err_q;
    assign out_valid = !fifo_empty_s;
    assign out_data  = fifo_rdata_s[DATA_WIDTH-1:0];
    assign out_size  = fifo_rdata_s[SIZE_WIDTH+DATA_WIDTH-1:DATA_WIDTH];

`ifdef CFS_MD_RESPONDER_STATS_EN
    logic [31:0] cnt_ok_q, cnt_err_q;

    // Saturating completion counters, bumped once per RESP cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_ok_q  <= 32'd0;
            cnt_err_q <= 32'd0;
        end else if (state_q == RESP) begin
            if (illegal_s) begin
                if (cnt_err_q != 32'hFFFF_FFFF) begin
                    cnt_err_q <= cnt_err_q + 32'd1;
                end
            end else if (cnt_ok_q != 32'hFFFF_FFFF) begin
                cnt_ok_q <= cnt_ok_q + 32'd1;
            end
        end
    end

    assign cnt_ok  = cnt_ok_q;
    assign cnt_err = cnt_err_q;
`endif

endmodule

// File: tb/tb_cfs_md_responder.sv
// Self-checking bench for cfs_md_responder (DATA_WIDTH=32, FIFO_DEPTH=4): directed
// scenarios with literal expectations plus randomized traffic against a reference model.
module tb_cfs_md_responder;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic        clk         = 1'b0;
    logic        reset_n     = 1'b0;
    logic        md_valid    = 1'b0;
    logic [31:0] md_data     = 32'h0;
    logic [1:0]  md_offset   = 2'd0;
    logic [2:0]  md_size     = 3'd0;
    logic [7:0]  wait_cycles = 8'd0;
    logic        out_ready   = 1'b0;
    logic        md_ready, md_err, out_valid;
    logic [31:0] out_data;
    logic [2:0]  out_size;
    logic [2:0]  fifo_level;
`ifdef CFS_MD_RESPONDER_STATS_EN
    logic [31:0] cnt_ok, cnt_err;
`endif

    int checks = 0;
    int errors = 0;

    cfs_md_responder #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .md_valid    (md_valid),
        .md_data     (md_data),
        .md_offset   (md_offset),
        .md_size     (md_size),
        .md_ready    (md_ready),
        .md_err      (md_err),
        .wait_cycles (wait_cycles),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_size    (out_size),
        .out_ready   (out_ready),
        .fifo_level  (fifo_level)
`ifdef CFS_MD_RESPONDER_STATS_EN
        ,
        .cnt_ok      (cnt_ok),
        .cnt_err     (cnt_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transfer with a remaining wait count,
    // and a queue of expected payloads standing in for the FIFO.
    typedef struct { logic [31:0] data; int size; } entry_t;
    entry_t      exp_q[$];
    int          m_phase;   // 0 none outstanding, 1 waiting, 2 responding
    int          m_cnt, m_off, m_size;
    logic [31:0] m_data;
    bit          m_legal, m_push, m_pop, m_room, m_ready, m_err;
    entry_t      m_ent;
    logic [63:0] m_wide;

    initial begin
        m_phase = 0; m_cnt = 0; m_ready = 0; m_err = 0; m_legal = 0;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                exp_q.delete();
                m_phase = 0; m_cnt = 0; m_ready = 0; m_err = 0;
            end else begin
                m_pop  = (exp_q.size() > 0) && out_ready;
                m_room = exp_q.size() < DEPTH;
                m_push = 0;
                if (m_phase == 0) begin
                    if (md_valid) begin
                        m_phase = 1;
                        m_cnt   = int'(wait_cycles);
                        m_data  = md_data;
                        m_off   = int'(md_offset);
                        m_size  = int'(md_size);
                        m_legal = (m_size != 0) && (m_off + m_size <= DW / 8);
                    end
                end else if (m_phase == 1) begin
                    if (!md_valid) m_phase = 0;
                    else if (m_cnt > 0) m_cnt = m_cnt - 1;
                    else if (!m_legal || m_room) m_phase = 2;
                end else begin
                    m_push  = m_legal;
                    m_phase = 0;
                end
                if (m_pop) void'(exp_q.pop_front());
                if (m_push) begin
                    m_wide     = {32'h0, m_data} >> (8 * m_off);
                    m_wide     = m_wide & ((64'h1 << (8 * m_size)) - 64'h1);
                    m_ent.data = m_wide[31:0];
                    m_ent.size = m_size;
                    exp_q.push_back(m_ent);
                end
                m_ready = (m_phase == 2);
                m_err   = m_ready && !m_legal;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                chk("md_ready", md_ready, m_ready);
                chk("md_err", md_err, m_err);
                chk("out_valid", out_valid, exp_q.size() > 0);
                chk("fifo_level", fifo_level, exp_q.size());
                if (exp_q.size() > 0) begin
                    chk("out_data", out_data, exp_q[0].data);
                    chk("out_size", out_size, exp_q[0].size);
                end
            end
        end
    end

    // Drive one transfer from a negedge; lat counts edges after acceptance until md_ready.
    task automatic xfer(input logic [31:0] d, input int off, input int sz, input int wc,
                        input bit rnd_pop, output int lat, output bit err_seen);
        bit done;
        md_valid = 1'b1; md_data = d; md_offset = off[1:0]; md_size = sz[2:0];
        wait_cycles = wc[7:0];
        lat = 0; err_seen = 0; done = 0;
        @(posedge clk);
        while (!done && lat < 500) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (md_ready) begin
                done = 1;
                err_seen = md_err;
            end else if (rnd_pop) begin
                out_ready = 1'($urandom_range(0, 1));
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL xfer_timeout: md_ready absent after %0d cycles, required within 500", lat);
        end
        md_valid = 1'b0;
        @(negedge clk);
    endtask

    int          lat, cnt;
    bit          err_seen, seen;
    logic [31:0] d;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_md_ready", md_ready, 0);
        chk("reset_md_err", md_err, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_fifo_level", fifo_level, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Zero wait states, legal transfer.
        xfer(32'hAABBCCDD, 1, 2, 0, 0, lat, err_seen);
        chk("t1_latency", lat, 1);
        chk("t1_err", err_seen, 0);
        chk("t1_out_data", out_data, 32'h0000BBCC);
        chk("t1_out_size", out_size, 2);
        chk("t1_level", fifo_level, 1);

        // Illegal transfers: overflow of byte lanes and zero size.
        xfer(32'h11223344, 3, 2, 0, 0, lat, err_seen);
        chk("t2_ovf_err", err_seen, 1);
        chk("t2_ovf_level", fifo_level, 1);
        xfer(32'h11223344, 0, 0, 0, 0, lat, err_seen);
        chk("t2_zero_err", err_seen, 1);
        chk("t2_zero_level", fifo_level, 1);

        // Three wait states.
        xfer(32'h55667788, 0, 4, 3, 0, lat, err_seen);
        chk("t3_latency", lat, 4);
        chk("t3_pulse_one_cycle", md_ready, 0);

        // Fill the FIFO, then back-pressure the fifth transfer.
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        chk("t4_flushed", fifo_level, 0);
        for (int i = 0; i < 4; i++) begin
            d = 32'h01020304 + 32'h10101010 * 32'(i);
            xfer(d, 0, 4, 0, 0, lat, err_seen);
        end
        chk("t4_level_full", fifo_level, 4);
        chk("t4_head", out_data, 32'h01020304);
        md_valid = 1'b1; md_data = 32'hCAFEF00D; md_offset = 2'd2; md_size = 3'd2;
        wait_cycles = 8'd0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (md_ready) seen = 1;
        end
        chk("t4_bp_hold", seen, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        cnt = 0; seen = 0;
        while (!seen && cnt < 20) begin
            @(negedge clk);
            cnt++;
            seen = md_ready;
        end
        chk("t4_release_lat", cnt, 1);
        md_valid = 1'b0;
        @(negedge clk);
        chk("t4_level_refill", fifo_level, 4);
        chk("t4_head_after_pop", out_data, 32'h11121314);

        // Async reset in the middle of a wait with two entries buffered.
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        chk("t5_level_before", fifo_level, 2);
        md_valid = 1'b1; md_data = 32'h99887766; md_offset = 2'd0; md_size = 3'd4;
        wait_cycles = 8'd20;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_md_ready", md_ready, 0);
        chk("t5_out_valid", out_valid, 0);
        chk("t5_fifo_level", fifo_level, 0);
        md_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Randomized traffic with random pops and occasional aborts.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                md_valid = 1'b1; md_data = $urandom; md_offset = 2'($urandom_range(0, 3));
                md_size = 3'($urandom_range(0, 4)); wait_cycles = 8'($urandom_range(0, 4));
                @(posedge clk);
                @(negedge clk);
                md_valid = 1'b0;
                @(negedge clk);
            end else begin
                xfer($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                     int'($urandom_range(0, 6)), 1, lat, err_seen);
            end
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                out_ready = 1'($urandom_range(0, 1));
            end
        end

`ifdef CFS_MD_RESPONDER_STATS_EN
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) xfer(32'h12345678, 0, 4, 1, 0, lat, err_seen);
        for (int i = 0; i < 2; i++) xfer(32'h12345678, 2, 3, 1, 0, lat, err_seen);
        chk("t6_cnt_ok", cnt_ok, 3);
        chk("t6_cnt_err", cnt_err, 2);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_cnt_ok_reset", cnt_ok, 0);
        chk("t6_cnt_err_reset", cnt_err, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
